ram_rd_arbiter: RTL and testbench
=================================

// Module: ram_rd_arbiter
// PURPOSE
// - Round-robin arbiter sharing the single read port of ram_1r1w_sync among num_req_p requesters.
// - Per-requester valid/ready on request and response; one read in flight; full throughput (1 read/cycle) under no backpressure.
// - Sits between client engines (tuner sample readers) and the RAM; the RAM write port is driven directly, not through this block.
// PARAMETERS
// - width_p    8    data width; must match the RAM
// - depth_p    512  RAM depth; address width aw = $clog2(depth_p)
// - num_req_p  2    number of requesters, legal range 2..8
// PORTS
// - clk_i           in   1             clock; all logic on posedge
// - reset_i         in   1             synchronous, active-high reset
// - req_valid_i     in   num_req_p     requester i has a read pending
// - req_addr_i      in   num_req_p*aw  address of requester i, slice [i*aw +: aw]
// - req_ready_o     out  num_req_p     one-hot grant; request i accepted when valid[i] & ready[i]
// - rsp_valid_o     out  num_req_p     one-hot; read data for requester i is on rsp_data_o
// - rsp_data_o      out  width_p       read data, shared by all requesters
// - rsp_ready_i     in   num_req_p     requester i accepts its response
// - ram_rd_valid_o  out  1             to RAM rd_valid_i
// - ram_rd_addr_o   out  aw            to RAM rd_addr_i
// - ram_rd_data_i   in   width_p       from RAM rd_data_o
// - stall_cnt_o     out  32            present only with RAMARB_STALL_CNT_EN
// BEHAVIOUR
// - Reset: rsp_valid_o=0, req_ready_o=0, ram_rd_valid_o=0, priority pointer=0, owner=0, stall_cnt_o=0.
// - Response slot: pend (1 bit) + owner index. pend=1 means rsp_valid_o[owner]=1.
// - can_grant = !pend | rsp_ready_i[owner]  (slot free, or being emptied this cycle).
// - Grant (combinational): if can_grant, first i with req_valid_i[i]=1 searching ptr, ptr+1, .. mod num_req_p;
//   req_ready_o = onehot(i); ram_rd_valid_o=1; ram_rd_addr_o = req_addr_i[i]. No valid request -> all 0, ram_rd_valid_o=0.
// - req_ready_o must not depend on req_valid_i of a non-winning requester beyond the search order; ready is 0 for i without valid.
// - Latency: request accepted in cycle t -> rsp_valid_o[i]=1 and rsp_data_o=ram_rd_data_i in cycle t+1.
// - Next state on grant to i: pend<=1, owner<=i, ptr<=(i+1) mod num_req_p.
// - No grant: if pend & rsp_ready_i[owner] then pend<=0; else hold. ptr unchanged.
// - Backpressure: while pend & !rsp_ready_i[owner], ram_rd_valid_o=0, so RAM output register holds and rsp_data_o stays stable.
// - rsp_ready_i bits of non-owners are ignored.
// - Back-to-back: response consumed and new grant in the same cycle -> pend stays 1, owner updates; no bubble.
// - Read/write same address same cycle: RAM returns the old contents; arbiter does not forward write data.
// - Reset mid-operation: pending response is dropped (rsp_valid_o=0 next cycle); requesters reissue.
// - Address is passed through unchanged; out-of-range address behaviour is the RAM's.
// CONFIGURATION
// - RAMARB_STALL_CNT_EN defined: stall_cnt_o is a 32-bit counter, +1 each cycle where |req_valid_i and no grant;
//   saturates at 32'hFFFF_FFFF; cleared by reset_i.
// - Undefined: stall_cnt_o port and its counter are absent; all other behaviour identical.
// TESTING (bench instantiates ram_1r1w_sync, num_req_p=2, RAM preloaded mem[k]=k[7:0])
// - Single read: req_valid_i=01, addr0=5, rsp_ready_i=11 -> req_ready_o=01 cycle t; rsp_valid_o=01, data=8'h05 at t+1.
// - Fairness: both valid continuously, addr0=1, addr1=2, ready=11 -> grants alternate 01,10,01,10 from reset; responses 1,2,1,2 every cycle.
// - Backpressure: grant to req0 addr 7, hold rsp_ready_i[0]=0 for 3 cycles with req1 valid -> rsp_data_o stays 8'h07, req_ready_o=00,
//   ram_rd_valid_o=0 throughout; ready[0]=1 -> req1 granted that same cycle, its response next cycle.
// - Read-during-write: write addr 9 data 8'hAA while reading addr 9 -> response 8'h09; re-read -> 8'hAA.
// - Reset mid-flight: assert reset_i the cycle after a grant -> rsp_valid_o=00, ptr=0 after reset; first post-reset grant to req0 when both valid.
// - With RAMARB_STALL_CNT_EN: hold rsp_ready_i=00 with both valid for 10 cycles after one grant -> stall_cnt_o=10.

Source files
------------

// File: rtl/ram_rd_arbiter.sv
// ============================================================================
// Module      : ram_rd_arbiter
// Description : Round-robin arbiter for the read port of ram_1r1w_sync, with
//               one read in flight and a single response slot.
//               Optional stall counter enabled by RAMARB_STALL_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_rd_arbiter #(
    parameter int width_p   = 8,
    parameter int depth_p   = 512,
    parameter int num_req_p = 2,
    localparam int c_aw     = $clog2(depth_p),
    localparam int c_iw     = $clog2(num_req_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [num_req_p-1:0]      req_valid_i,
    input  logic [num_req_p*c_aw-1:0] req_addr_i,
    output logic [num_req_p-1:0]      req_ready_o,
    output logic [num_req_p-1:0]      rsp_valid_o,
    output logic [width_p-1:0]        rsp_data_o,
    input  logic [num_req_p-1:0]      rsp_ready_i,
    output logic                      ram_rd_valid_o,
    output logic [c_aw-1:0]           ram_rd_addr_o,
    input  logic [width_p-1:0]        ram_rd_data_i
`ifdef RAMARB_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    localparam logic [num_req_p-1:0] c_one = {{(num_req_p-1){1'b0}}, 1'b1};

    logic            r_pend;
    logic [c_iw-1:0] r_owner;
    logic [c_iw-1:0] r_ptr;

    logic            w_can_grant;
    logic            w_found;
    logic [c_iw-1:0] w_win;

    // Index of the k-th requester in search order starting at ptr.
    function automatic logic [c_iw-1:0] f_rr_idx(input logic [c_iw-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= num_req_p) begin
            s = s - num_req_p;
        end
        return c_iw'(s);
    endfunction

    // Slot is free, or its owner drains it this cycle. Reset blocks new grants.
    assign w_can_grant = !reset_i && (!r_pend || rsp_ready_i[r_owner]);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        if (w_can_grant) begin
            for (int k = 0; k < num_req_p; k++) begin
                if (!w_found && req_valid_i[f_rr_idx(r_ptr, k)]) begin
                    w_found = 1'b1;
                    w_win   = f_rr_idx(r_ptr, k);
                end
            end
        end
    end

    assign req_ready_o    = w_found ? (c_one << w_win) : '0;
    assign ram_rd_valid_o = w_found;
    assign ram_rd_addr_o  = req_addr_i[w_win*c_aw +: c_aw];
    assign rsp_valid_o    = r_pend ? (c_one << r_owner) : '0;
    // RAM output register holds while no read is issued, so data stays stable.
    assign rsp_data_o     = ram_rd_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pend  <= 1'b0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_found) begin
            r_pend  <= 1'b1;
            r_owner <= w_win;
            r_ptr   <= f_rr_idx(w_win, 1);
        end else if (r_pend && rsp_ready_i[r_owner]) begin
            r_pend  <= 1'b0;
        end
    end

`ifdef RAMARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if ((|req_valid_i) && !w_found && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_rd_arbiter.sv
// Directed bench for ram_rd_arbiter with a behavioural 1R1W synchronous RAM.
`default_nettype none

module tb_ram_rd_arbiter;

    localparam int W  = 8;
    localparam int D  = 512;
    localparam int N  = 2;
    localparam int AW = $clog2(D);

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_valid_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    rsp_valid_o;
    logic [W-1:0]    rsp_data_o;
    logic [N-1:0]    rsp_ready_i;
    logic            ram_rd_valid_o;
    logic [AW-1:0]   ram_rd_addr_o;
    logic [W-1:0]    ram_rd_data;
`ifdef RAMARB_STALL_CNT_EN
    logic [31:0]     stall_cnt_o;
`endif

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [W-1:0]    wr_data;
    logic [W-1:0]    mem [D];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Synchronous RAM: read returns old contents on a same-address write.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (ram_rd_valid_o) ram_rd_data <= mem[ram_rd_addr_o];
    end

    ram_rd_arbiter #(.width_p(W), .depth_p(D), .num_req_p(N)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_addr_i     (req_addr_i),
        .req_ready_o    (req_ready_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_ready_i    (rsp_ready_i),
        .ram_rd_valid_o (ram_rd_valid_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_rd_data_i  (ram_rd_data)
`ifdef RAMARB_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let comb logic settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int a0, input int a1);
        req_addr_i = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < D; k++) mem[k] = W'(k);
        reset_i = 1'b1; req_valid_i = '0; rsp_ready_i = '1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; set_addr(0, 0);

        // Reset state, even with requests present
        tick(); tick();
        req_valid_i = 2'b11; settle();
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_ram_rd_valid", 32'(ram_rd_valid_o), 32'h0);
        req_valid_i = '0;
        tick(); reset_i = 1'b0; settle();

        // Single read
        req_valid_i = 2'b01; set_addr(5, 0); settle();
        chk("single_ready", 32'(req_ready_o), 32'h1);
        chk("single_ram_valid", 32'(ram_rd_valid_o), 32'h1);
        chk("single_ram_addr", 32'(ram_rd_addr_o), 32'd5);
        tick(); req_valid_i = '0; settle();
        chk("single_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("single_rsp_data", 32'(rsp_data_o), 32'h05);
        chk("single_idle_ready", 32'(req_ready_o), 32'h0);
        tick();

        // Fairness from reset
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        req_valid_i = 2'b11; set_addr(1, 2); settle();
        chk("fair_g0", 32'(req_ready_o), 32'h1);
        tick();
        chk("fair_g1", 32'(req_ready_o), 32'h2);
        chk("fair_r1_valid", 32'(rsp_valid_o), 32'h1);
        chk("fair_r1_data", 32'(rsp_data_o), 32'd1);
        tick();
        chk("fair_g2", 32'(req_ready_o), 32'h1);
        chk("fair_r2_valid", 32'(rsp_valid_o), 32'h2);
        chk("fair_r2_data", 32'(rsp_data_o), 32'd2);
        tick();
        chk("fair_g3", 32'(req_ready_o), 32'h2);
        chk("fair_r3_data", 32'(rsp_data_o), 32'd1);
        tick(); req_valid_i = '0; settle();
        chk("fair_r4_valid", 32'(rsp_valid_o), 32'h2);
        chk("fair_r4_data", 32'(rsp_data_o), 32'd2);
        tick();
        chk("fair_drained", 32'(rsp_valid_o), 32'h0);

        // Backpressure: owner 0 stalls, req1 waits
        req_valid_i = 2'b01; set_addr(7, 3); settle();
        chk("bp_grant0", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i = 2'b10; rsp_ready_i = 2'b10;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("bp_hold_valid", 32'(rsp_valid_o), 32'h1);
            chk("bp_hold_data", 32'(rsp_data_o), 32'h07);
            chk("bp_hold_ready", 32'(req_ready_o), 32'h0);
            chk("bp_hold_ram_valid", 32'(ram_rd_valid_o), 32'h0);
            tick();
        end
        rsp_ready_i = 2'b11; settle();
        chk("bp_release_grant1", 32'(req_ready_o), 32'h2);
        chk("bp_release_data", 32'(rsp_data_o), 32'h07);
        tick(); req_valid_i = '0; settle();
        chk("bp_r1_valid", 32'(rsp_valid_o), 32'h2);
        chk("bp_r1_data", 32'(rsp_data_o), 32'h03);
        tick();

        // Read during write returns old contents
        req_valid_i = 2'b01; set_addr(9, 0);
        wr_en = 1'b1; wr_addr = AW'(9); wr_data = 8'hAA; settle();
        chk("rdw_grant", 32'(req_ready_o), 32'h1);
        tick(); wr_en = 1'b0; settle();
        chk("rdw_old_data", 32'(rsp_data_o), 32'h09);
        chk("rdw_regrant", 32'(req_ready_o), 32'h1);
        tick(); req_valid_i = '0; settle();
        chk("rdw_new_data", 32'(rsp_data_o), 32'hAA);
        tick();

        // Reset mid-flight (pointer currently 1)
        req_valid_i = 2'b11; set_addr(1, 2); settle();
        chk("midrst_grant1", 32'(req_ready_o), 32'h2);
        tick(); reset_i = 1'b1; settle();
        chk("midrst_during_ready", 32'(req_ready_o), 32'h0);
        tick(); reset_i = 1'b0; settle();
        chk("midrst_dropped", 32'(rsp_valid_o), 32'h0);
        chk("midrst_first_grant", 32'(req_ready_o), 32'h1);
        tick(); req_valid_i = '0; settle();
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("midrst_rsp_data", 32'(rsp_data_o), 32'd1);
        tick();

`ifdef RAMARB_STALL_CNT_EN
        reset_i = 1'b1; tick(); reset_i = 1'b0; settle();
        chk("stall_reset", stall_cnt_o, 32'd0);
        req_valid_i = 2'b11; rsp_ready_i = 2'b00; settle();
        chk("stall_first_grant", 32'(req_ready_o), 32'h1);
        tick();
        for (int c = 0; c < 10; c++) tick();
        chk("stall_cnt_10", stall_cnt_o, 32'd10);
        req_valid_i = '0; rsp_ready_i = 2'b11;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
